door_drive_model: RTL and testbench

//  Motor-side counterpart of the door controller. Consumes motor commands (open/close

---
 rtl/door_drive_if.sv | 24 ++
 rtl/door_drive_model.sv | 124 ++++++++++++
 tb/tb_door_drive_model.sv | 135 +++++++++++++
 3 files changed

// File: rtl/door_drive_if.sv
// Controller <-> door-leaf drive signals: motor commands out, limit/status feedback back.
interface door_drive_if #(
  parameter int PW = 5
);
  logic          m2o;
  logic          m2c;
  logic          obs;
  logic [PW-1:0] pos;
  logic          lim_closed;
  logic          lim_open;
  logic          moving;
  logic          stall;
  logic          cmd_err;

  modport master (
    output m2o, m2c, obs,
    input  pos, lim_closed, lim_open, moving, stall, cmd_err
  );

  modport slave (
    input  m2o, m2c, obs,
    output pos, lim_closed, lim_open, moving, stall, cmd_err
  );
endinterface

// File: rtl/door_drive_model.sv
// Stepper-driven door leaf model: tracks position from motor commands and reports
// limit switches, stall on obstructed closing, and illegal-command errors.
module door_drive_model #(
  parameter int TRAVEL    = 16,
  parameter int STEP_DIV  = 4,
  parameter int STALL_CYC = 8
) (
  input  logic         clk,
  input  logic         reset,
  door_drive_if.slave  bus
);
  localparam int PW = $clog2(TRAVEL+1);
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = $clog2(STALL_CYC+1);
  localparam logic [PW-1:0] TRAV      = PW'(TRAVEL);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV-1);
  localparam logic [CW-1:0] STALL_MAX = CW'(STALL_CYC);

  typedef enum logic [2:0] {IDLE, OPENING, CLOSING, STALLED, ERROR} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [SW-1:0]   step_q, step_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic            frozen;
  logic            both;
  logic            lim_closed_q, lim_open_q, moving_q, stall_flag_q, cmd_err_q;

  assign both = bus.m2o & bus.m2c;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    step_d  = step_q;
    stall_d = stall_q;
    frozen  = 1'b0;
    case (state_q)
      IDLE: begin
        if (both)                            state_d = ERROR;
        else if (bus.m2o && pos_q != TRAV)   state_d = OPENING;
        else if (bus.m2c && pos_q != '0)     state_d = CLOSING;
      end
      OPENING: begin
        if (both) state_d = ERROR;
        else if (!bus.m2o) begin
          step_d  = '0;
          state_d = (bus.m2c && pos_q != '0) ? CLOSING : IDLE;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          pos_d  = pos_q + PW'(1);
          if (pos_q == TRAV - PW'(1)) state_d = IDLE;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      CLOSING: begin
        if (both) state_d = ERROR;
        else if (bus.m2o) begin
          step_d  = '0;
          state_d = (pos_q != TRAV) ? OPENING : IDLE;
        end else if (!bus.m2c) begin
          state_d = IDLE;
        end else if (bus.obs) begin
          // obstruction freezes the partial step rather than discarding it
          frozen  = 1'b1;
          stall_d = stall_q + CW'(1);
          if (stall_q + CW'(1) == STALL_MAX) state_d = STALLED;
        end else begin
          stall_d = '0;
          if (step_q == STEP_LAST) begin
            step_d = '0;
            pos_d  = pos_q - PW'(1);
            if (pos_q == PW'(1)) state_d = IDLE;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      STALLED: begin
        if (both)          state_d = ERROR;
        else if (bus.m2o)  state_d = (pos_q != TRAV) ? OPENING : IDLE;
        else if (!bus.m2c) state_d = IDLE;
      end
      ERROR: begin
        if (!bus.m2o && !bus.m2c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // counters only carry meaning while actively travelling
    if (state_d != OPENING && state_d != CLOSING) step_d = '0;
    if (state_d != CLOSING) stall_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      step_q       <= '0;
      stall_q      <= '0;
      lim_closed_q <= 1'b1;
      lim_open_q   <= 1'b0;
      moving_q     <= 1'b0;
      stall_flag_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      step_q       <= step_d;
      stall_q      <= stall_d;
      lim_closed_q <= (pos_d == '0);
      lim_open_q   <= (pos_d == TRAV);
      moving_q     <= (state_d == OPENING || state_d == CLOSING) && !frozen;
      stall_flag_q <= (state_d == STALLED);
      cmd_err_q    <= (state_d == ERROR);
    end
  end

  assign bus.pos        = pos_q;
  assign bus.lim_closed = lim_closed_q;
  assign bus.lim_open   = lim_open_q;
  assign bus.moving     = moving_q;
  assign bus.stall      = stall_flag_q;
  assign bus.cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_door_drive_model.sv
// Directed bench for door_drive_model: driver queues expected leaf status per edge,
// an independent monitor pops and compares after each clock edge or reset assertion.
module tb_door_drive_model;
  logic clk;
  logic reset;

  door_drive_if #(.PW(5)) bus ();

  door_drive_model #(.TRAVEL(16), .STEP_DIV(4), .STALL_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string tag;
    int    pos;
    bit    mv;
    bit    st;
    bit    er;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor: one expectation per clock edge or async reset assertion
  initial begin
    exp_t e;
    bit   elc, elo;
    forever begin
      @(posedge clk or negedge reset);
      #2;
      if (q.size() > 0) begin
        e   = q.pop_front();
        elc = (e.pos == 0);
        elo = (e.pos == 16);
        n_chk++;
        if (int'(bus.pos) != e.pos || bus.lim_closed !== elc || bus.lim_open !== elo ||
            bus.moving !== e.mv || bus.stall !== e.st || bus.cmd_err !== e.er) begin
          n_fail++;
          $display("FAIL %s: got pos=%0d lc=%0b lo=%0b mv=%0b st=%0b err=%0b, expected pos=%0d lc=%0b lo=%0b mv=%0b st=%0b err=%0b",
                   e.tag, bus.pos, bus.lim_closed, bus.lim_open, bus.moving, bus.stall, bus.cmd_err,
                   e.pos, elc, elo, e.mv, e.st, e.er);
        end
      end
    end
  end

  task automatic cyc(input bit o, input bit c, input bit ob, input string tag,
                     input int ep, input bit mv, input bit st = 1'b0, input bit er = 1'b0);
    exp_t e;
    bus.m2o = o;
    bus.m2c = c;
    bus.obs = ob;
    e.tag = tag; e.pos = ep; e.mv = mv; e.st = st; e.er = er;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    bus.m2o = 1'b0;
    bus.m2c = 1'b0;
    bus.obs = 1'b0;
    reset   = 1'b1;
    e.tag = "reset"; e.pos = 0; e.mv = 1'b0; e.st = 1'b0; e.er = 1'b0;
    q.push_back(e);
    #1 reset = 1'b0;
    #3;
    cyc(1'b1, 1'b0, 1'b0, "reset_held", 0, 1'b0);
    reset = 1'b1;

    // T1: full open from closed
    for (int k = 0; k <= 64; k++) cyc(1'b1, 1'b0, 1'b0, "t1_open", k/4, k < 64);
    cyc(1'b1, 1'b0, 1'b0, "t1_endstop", 16, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, "t1_idle", 16, 1'b0);

    // T3: close to mid-travel, obstruct until stall, then reopen
    for (int k = 0; k <= 32; k++) cyc(1'b0, 1'b1, 1'b0, "t3_close", 16 - k/4, 1'b1);
    for (int k = 1; k <= 8; k++) cyc(1'b0, 1'b1, 1'b1, "t3_obs", 8, 1'b0, k == 8);
    cyc(1'b0, 1'b1, 1'b0, "t3_stall_hold", 8, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, "t3_reopen", 8, 1'b1);
    for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b0, 1'b1, "t3_open", (k == 4) ? 9 : 8, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, "t3_stop", 9, 1'b0);

    // T4: short obstruction freezes the partial step
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, "t4_close", 9, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b1, "t4_obs", 9, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, "t4_resume", 9, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, "t4_resume", 8, 1'b1);
    for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b1, 1'b0, "t4_run", (k == 4) ? 7 : 8, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, "t4_stop", 7, 1'b0);

    // T2: close to the end stop and keep pushing
    for (int k = 0; k <= 28; k++) cyc(1'b0, 1'b1, 1'b0, "t2_close", 7 - k/4, k < 28);
    cyc(1'b0, 1'b1, 1'b0, "t2_hold", 0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, "t2_hold", 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, "t2_idle", 0, 1'b0);

    // T5: illegal command at pos 5
    for (int k = 0; k <= 20; k++) cyc(1'b1, 1'b0, 1'b0, "t5_open", k/4, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, "t5_both", 5, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, "t5_hold_err", 5, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, "t5_clear", 5, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, "t5_idle_both", 5, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, "t5_clear2", 5, 1'b0);

    // T6: async reset while opening at pos 12
    for (int k = 0; k <= 29; k++) cyc(1'b1, 1'b0, 1'b0, "t6_open", 5 + k/4, 1'b1);
    e.tag = "t6_async"; e.pos = 0; e.mv = 1'b0; e.st = 1'b0; e.er = 1'b0;
    q.push_back(e);
    #2 reset = 1'b0;
    #3;
    cyc(1'b1, 1'b0, 1'b0, "t6_in_reset", 0, 1'b0);
    reset = 1'b1;
    for (int k = 0; k <= 4; k++) cyc(1'b1, 1'b0, 1'b0, "t6_rehome", k/4, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, "t6_stop", 1, 1'b0);

    #5;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
